gpout_ctrl: RTL and testbench

GPOUT_CTRL -- requirements
Module: gpout_ctrl

---
 rtl/gpout_pkg.sv | 37 +++
 rtl/gpout_if.sv | 32 +++
 rtl/gpout_pulse.sv | 68 ++++++
 rtl/gpout_ctrl.sv | 74 +++++++
 tb/tb_gpout_ctrl.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/gpout_pkg.sv
// Shared constants, command encodings and mask helpers for the general-purpose
// output controller.
package gpout_pkg;

    localparam int GPOUT_W     = 32;
    localparam int PULSE_LEN_W = 16;
    localparam int PULSE_BIT_W = 5;

    typedef enum logic [1:0] {
        CMD_WRITE  = 2'b00,
        CMD_SET    = 2'b01,
        CMD_CLEAR  = 2'b10,
        CMD_TOGGLE = 2'b11
    } cmd_e;

    function automatic logic [GPOUT_W-1:0] onehot(input logic [PULSE_BIT_W-1:0] idx);
        logic [GPOUT_W-1:0] m;
        m      = {GPOUT_W{1'b0}};
        m[idx] = 1'b1;
        return m;
    endfunction

    function automatic logic [GPOUT_W-1:0] apply_cmd(input logic [GPOUT_W-1:0] cur,
                                                     input logic [1:0]         cmd,
                                                     input logic [GPOUT_W-1:0] data);
        logic [GPOUT_W-1:0] r;
        case (cmd)
            CMD_WRITE:  r = data;
            CMD_SET:    r = cur | data;
            CMD_CLEAR:  r = cur & ~data;
            CMD_TOGGLE: r = cur ^ data;
            default:    r = cur;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/gpout_if.sv
// Bus bundle between the two command requesters / pulse source (master) and
// the output controller (slave).
interface gpout_if;
    import gpout_pkg::*;

    logic                   req_a;
    logic [1:0]             cmd_a;
    logic [GPOUT_W-1:0]     data_a;
    logic                   ack_a;
    logic                   req_b;
    logic [1:0]             cmd_b;
    logic [GPOUT_W-1:0]     data_b;
    logic                   ack_b;
    logic                   pulse_start;
    logic [PULSE_BIT_W-1:0] pulse_bit;
    logic [PULSE_LEN_W-1:0] pulse_len;
    logic                   pulse_busy;
    logic [GPOUT_W-1:0]     gpout;

    modport master (
        output req_a, cmd_a, data_a, req_b, cmd_b, data_b,
               pulse_start, pulse_bit, pulse_len,
        input  ack_a, ack_b, pulse_busy, gpout
    );

    modport slave (
        input  req_a, cmd_a, data_a, req_b, cmd_b, data_b,
               pulse_start, pulse_bit, pulse_len,
        output ack_a, ack_b, pulse_busy, gpout
    );

endinterface

// File: rtl/gpout_pulse.sv
// Two-state pulse engine: inverts one latched output bit for a programmed
// number of cycles; exports the next-cycle overlay so the parent can register gpout.
module gpout_pulse
    import gpout_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start_i,
    input  logic [PULSE_BIT_W-1:0] bit_i,
    input  logic [PULSE_LEN_W-1:0] len_i,
    output logic                   busy_o,
    output logic [GPOUT_W-1:0]     overlay_nxt_o
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_PULSE = 1'b1;

    logic [0:0]             state_q, state_d;
    logic [PULSE_LEN_W-1:0] cnt_q,   cnt_d;
    logic [PULSE_BIT_W-1:0] bit_q,   bit_d;

    // Next-state logic; starts while busy are dropped, not queued.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i && (len_i != {PULSE_LEN_W{1'b0}})) begin
                    state_d = ST_PULSE;
                    cnt_d   = len_i;
                    bit_d   = bit_i;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PULSE: begin
                if (cnt_q <= {{(PULSE_LEN_W-1){1'b0}}, 1'b1}) begin
                    state_d = ST_IDLE;
                    cnt_d   = {PULSE_LEN_W{1'b0}};
                end else begin
                    cnt_d   = cnt_q - {{(PULSE_LEN_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = {PULSE_LEN_W{1'b0}};
            end
        endcase
        overlay_nxt_o = (state_d == ST_PULSE) ? onehot(bit_d) : {GPOUT_W{1'b0}};
    end

    // State, counter and latched bit registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= {PULSE_LEN_W{1'b0}};
            bit_q   <= {PULSE_BIT_W{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
        end
    end

    assign busy_o = (state_q == ST_PULSE);

endmodule

// File: rtl/gpout_ctrl.sv
// General-purpose output controller: round-robin arbitration of two command
// requesters onto out_reg, with a single-bit timed inversion overlaid on gpout.
module gpout_ctrl
    import gpout_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    gpout_if.slave  bus
);

    logic [GPOUT_W-1:0] out_reg_q, out_reg_d;
    logic [GPOUT_W-1:0] gpout_q,   gpout_d;
    logic               ack_a_q,   ack_a_d;
    logic               ack_b_q,   ack_b_d;
    logic               last_b_q,  last_b_d;
    logic               elig_a, elig_b, grant_a, grant_b;
    logic               pulse_busy;
    logic [GPOUT_W-1:0] overlay_nxt;

    gpout_pulse u_pulse (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_i       (bus.pulse_start),
        .bit_i         (bus.pulse_bit),
        .len_i         (bus.pulse_len),
        .busy_o        (pulse_busy),
        .overlay_nxt_o (overlay_nxt)
    );

    // Arbitration and command application; an acked requester sits out one edge.
    always_comb begin
        elig_a    = bus.req_a & ~ack_a_q;
        elig_b    = bus.req_b & ~ack_b_q;
        grant_a   = elig_a & (~elig_b | last_b_q);
        grant_b   = elig_b & ~grant_a;
        out_reg_d = out_reg_q;
        last_b_d  = last_b_q;
        if (grant_a) begin
            out_reg_d = apply_cmd(out_reg_q, bus.cmd_a, bus.data_a);
            last_b_d  = 1'b0;
        end else if (grant_b) begin
            out_reg_d = apply_cmd(out_reg_q, bus.cmd_b, bus.data_b);
            last_b_d  = 1'b1;
        end else begin
            last_b_d  = last_b_q;
        end
        ack_a_d = grant_a;
        ack_b_d = grant_b;
        gpout_d = out_reg_d ^ overlay_nxt;
    end

    // Output word, acks and round-robin pointer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_reg_q <= {GPOUT_W{1'b0}};
            gpout_q   <= {GPOUT_W{1'b0}};
            ack_a_q   <= 1'b0;
            ack_b_q   <= 1'b0;
            last_b_q  <= 1'b1;
        end else begin
            out_reg_q <= out_reg_d;
            gpout_q   <= gpout_d;
            ack_a_q   <= ack_a_d;
            ack_b_q   <= ack_b_d;
            last_b_q  <= last_b_d;
        end
    end

    assign bus.ack_a      = ack_a_q;
    assign bus.ack_b      = ack_b_q;
    assign bus.pulse_busy = pulse_busy;
    assign bus.gpout      = gpout_q;

endmodule

// File: tb/tb_gpout_ctrl.sv
// Directed self-checking bench for gpout_ctrl; observed word is {ack_a, ack_b, pulse_busy, gpout}.
module tb_gpout_ctrl;
    import gpout_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    logic [34:0] obs;

    gpout_if bus ();

    gpout_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign obs = {bus.ack_a, bus.ack_b, bus.pulse_busy, bus.gpout};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req_a = 1'b0; bus.cmd_a = 2'b00; bus.data_a = 32'h0;
        bus.req_b = 1'b0; bus.cmd_b = 2'b00; bus.data_b = 32'h0;
        bus.pulse_start = 1'b0; bus.pulse_bit = 5'd0; bus.pulse_len = 16'd0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (obs !== {1'b0, 1'b0, 1'b0, 32'h0000_0000}) begin
            errors++; $display("FAIL reset_state: got %h expected %h", obs, 35'h0);
        end
        step();
        checks++;
        if (obs !== {1'b0, 1'b0, 1'b0, 32'h0000_0000}) begin
            errors++; $display("FAIL reset_release: got %h expected %h", obs, 35'h0);
        end
    endtask

    task automatic test_write();
        bus.req_a = 1'b1; bus.cmd_a = 2'b00; bus.data_a = 32'h0000_00F0;
        step();
        checks++;
        if (obs !== {1'b1, 1'b0, 1'b0, 32'h0000_00F0}) begin
            errors++; $display("FAIL write_ack: got %h expected %h", obs, {1'b1, 1'b0, 1'b0, 32'h0000_00F0});
        end
        bus.req_a = 1'b0;
        step();
        checks++;
        if (obs !== {1'b0, 1'b0, 1'b0, 32'h0000_00F0}) begin
            errors++; $display("FAIL write_ack_one_cycle: got %h expected %h", obs, {1'b0, 1'b0, 1'b0, 32'h0000_00F0});
        end
    endtask

    task automatic test_arbitration();
        do_reset();
        bus.req_b = 1'b1; bus.cmd_b = 2'b00; bus.data_b = 32'h0000_00F0;
        step();
        checks++;
        if (obs !== {1'b0, 1'b1, 1'b0, 32'h0000_00F0}) begin
            errors++; $display("FAIL arb_b_write: got %h expected %h", obs, {1'b0, 1'b1, 1'b0, 32'h0000_00F0});
        end
        bus.req_b = 1'b0;
        step();
        bus.req_a = 1'b1; bus.cmd_a = 2'b01; bus.data_a = 32'h0000_0001;
        bus.req_b = 1'b1; bus.cmd_b = 2'b10; bus.data_b = 32'h0000_0010;
        step();
        checks++;
        if (obs !== {1'b1, 1'b0, 1'b0, 32'h0000_00F1}) begin
            errors++; $display("FAIL arb_a_first: got %h expected %h", obs, {1'b1, 1'b0, 1'b0, 32'h0000_00F1});
        end
        bus.req_a = 1'b0;
        step();
        checks++;
        if (obs !== {1'b0, 1'b1, 1'b0, 32'h0000_00E1}) begin
            errors++; $display("FAIL arb_b_second: got %h expected %h", obs, {1'b0, 1'b1, 1'b0, 32'h0000_00E1});
        end
        bus.req_b = 1'b0;
        step();
        checks++;
        if (obs !== {1'b0, 1'b0, 1'b0, 32'h0000_00E1}) begin
            errors++; $display("FAIL arb_quiet: got %h expected %h", obs, {1'b0, 1'b0, 1'b0, 32'h0000_00E1});
        end
    endtask

    task automatic test_held_toggle();
        bus.req_a = 1'b1; bus.cmd_a = 2'b11; bus.data_a = 32'h8000_0000;
        step();
        checks++;
        if (obs !== {1'b1, 1'b0, 1'b0, 32'h8000_00E1}) begin
            errors++; $display("FAIL toggle_ack: got %h expected %h", obs, {1'b1, 1'b0, 1'b0, 32'h8000_00E1});
        end
        step();
        checks++;
        if (obs !== {1'b0, 1'b0, 1'b0, 32'h8000_00E1}) begin
            errors++; $display("FAIL toggle_once: got %h expected %h", obs, {1'b0, 1'b0, 1'b0, 32'h8000_00E1});
        end
        bus.req_a = 1'b0;
        step();
        checks++;
        if (obs !== {1'b0, 1'b0, 1'b0, 32'h8000_00E1}) begin
            errors++; $display("FAIL toggle_settled: got %h expected %h", obs, {1'b0, 1'b0, 1'b0, 32'h8000_00E1});
        end
    endtask

    task automatic test_pulse();
        do_reset();
        bus.pulse_start = 1'b1; bus.pulse_bit = 5'd3; bus.pulse_len = 16'd5;
        step();
        bus.pulse_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (obs !== {1'b0, 1'b0, 1'b1, 32'h0000_0008}) begin
                errors++; $display("FAIL pulse_active[%0d]: got %h expected %h", i, obs, {1'b0, 1'b0, 1'b1, 32'h0000_0008});
            end
            if (i == 1) begin
                bus.pulse_start = 1'b1; bus.pulse_bit = 5'd7; bus.pulse_len = 16'd2;
            end else if (i == 2) begin
                bus.pulse_start = 1'b0;
            end
            step();
        end
        checks++;
        if (obs !== {1'b0, 1'b0, 1'b0, 32'h0000_0000}) begin
            errors++; $display("FAIL pulse_end: got %h expected %h", obs, 35'h0);
        end
        bus.pulse_start = 1'b1; bus.pulse_bit = 5'd0; bus.pulse_len = 16'd1;
        step();
        bus.pulse_start = 1'b0;
        checks++;
        if (obs !== {1'b0, 1'b0, 1'b1, 32'h0000_0001}) begin
            errors++; $display("FAIL pulse_restart: got %h expected %h", obs, {1'b0, 1'b0, 1'b1, 32'h0000_0001});
        end
        step();
        checks++;
        if (obs !== {1'b0, 1'b0, 1'b0, 32'h0000_0000}) begin
            errors++; $display("FAIL pulse_len1_end: got %h expected %h", obs, 35'h0);
        end
    endtask

    task automatic test_pulse_with_write();
        bus.pulse_start = 1'b1; bus.pulse_bit = 5'd3; bus.pulse_len = 16'd4;
        step();
        bus.pulse_start = 1'b0;
        bus.req_a = 1'b1; bus.cmd_a = 2'b01; bus.data_a = 32'h0000_0008;
        step();
        bus.req_a = 1'b0;
        checks++;
        if (obs !== {1'b1, 1'b0, 1'b1, 32'h0000_0000}) begin
            errors++; $display("FAIL pw_set_during_pulse: got %h expected %h", obs, {1'b1, 1'b0, 1'b1, 32'h0000_0000});
        end
        step();
        step();
        checks++;
        if (obs !== {1'b0, 1'b0, 1'b1, 32'h0000_0000}) begin
            errors++; $display("FAIL pw_last_pulse_cycle: got %h expected %h", obs, {1'b0, 1'b0, 1'b1, 32'h0000_0000});
        end
        step();
        checks++;
        if (obs !== {1'b0, 1'b0, 1'b0, 32'h0000_0008}) begin
            errors++; $display("FAIL pw_after_pulse: got %h expected %h", obs, {1'b0, 1'b0, 1'b0, 32'h0000_0008});
        end
        bus.pulse_start = 1'b1; bus.pulse_bit = 5'd5; bus.pulse_len = 16'd0;
        step();
        step();
        bus.pulse_start = 1'b0;
        checks++;
        if (obs !== {1'b0, 1'b0, 1'b0, 32'h0000_0008}) begin
            errors++; $display("FAIL pw_len_zero: got %h expected %h", obs, {1'b0, 1'b0, 1'b0, 32'h0000_0008});
        end
    endtask

    task automatic test_same_edge();
        bus.req_b = 1'b1; bus.cmd_b = 2'b00; bus.data_b = 32'h0000_0100;
        bus.pulse_start = 1'b1; bus.pulse_bit = 5'd0; bus.pulse_len = 16'd2;
        step();
        bus.req_b = 1'b0; bus.pulse_start = 1'b0;
        checks++;
        if (obs !== {1'b0, 1'b1, 1'b1, 32'h0000_0101}) begin
            errors++; $display("FAIL same_edge: got %h expected %h", obs, {1'b0, 1'b1, 1'b1, 32'h0000_0101});
        end
        step();
        step();
        checks++;
        if (obs !== {1'b0, 1'b0, 1'b0, 32'h0000_0100}) begin
            errors++; $display("FAIL same_edge_end: got %h expected %h", obs, {1'b0, 1'b0, 1'b0, 32'h0000_0100});
        end
    endtask

    task automatic test_reset_mid();
        bus.pulse_start = 1'b1; bus.pulse_bit = 5'd2; bus.pulse_len = 16'd10;
        step();
        bus.pulse_start = 1'b0;
        bus.req_a = 1'b1; bus.cmd_a = 2'b00; bus.data_a = 32'h0000_0055;
        bus.req_b = 1'b1; bus.cmd_b = 2'b01; bus.data_b = 32'h0000_00F0;
        step();
        checks++;
        if (obs !== {1'b1, 1'b0, 1'b1, 32'h0000_0051}) begin
            errors++; $display("FAIL rm_a_wins: got %h expected %h", obs, {1'b1, 1'b0, 1'b1, 32'h0000_0051});
        end
        bus.req_a = 1'b0;
        rst_n = 1'b0;
        step();
        checks++;
        if (obs !== {1'b0, 1'b0, 1'b0, 32'h0000_0000}) begin
            errors++; $display("FAIL rm_in_reset: got %h expected %h", obs, 35'h0);
        end
        bus.req_b = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (obs !== {1'b0, 1'b0, 1'b0, 32'h0000_0000}) begin
                errors++; $display("FAIL rm_after_release[%0d]: got %h expected %h", i, obs, 35'h0);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        idle_inputs();
        test_reset();
        test_write();
        test_arbitration();
        test_held_toggle();
        test_pulse();
        test_pulse_with_write();
        test_same_edge();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
